// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch queue: entry layout and PC stride.
package fetch_pkg;

    localparam int INST_W  = 32;
    localparam int PC_W    = 8;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle around the fetch queue.
// master = fetch/decode side driving bundles and takes, slave = the queue.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic              flush;
    logic              in_valid;
    logic [PC_W-1:0]   in_pc;
    logic [INST_W-1:0] in_inst1;
    logic [INST_W-1:0] in_inst2;
    logic              in_ready;
    logic [1:0]        out_valid;
    logic [INST_W-1:0] out_inst0;
    logic [PC_W-1:0]   out_pc0;
    logic [INST_W-1:0] out_inst1;
    logic [PC_W-1:0]   out_pc1;
    logic [1:0]        out_take;

    modport master (
        output flush, in_valid, in_pc, in_inst1, in_inst2, out_take,
        input  in_ready, out_valid, out_inst0, out_pc0, out_inst1, out_pc1
    );

    modport slave (
        input  flush, in_valid, in_pc, in_inst1, in_inst2, out_take,
        output in_ready, out_valid, out_inst0, out_pc0, out_inst1, out_pc1
    );

endinterface

// File: rtl/fq_storage.sv
// Entry array for the fetch queue: two write ports (one bundle per cycle)
// and two asynchronous read ports (the two oldest slots).
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr0,
    input  logic [$clog2(DEPTH)-1:0] waddr1,
    input  fq_entry_t                wdata0,
    input  fq_entry_t                wdata1,
    input  logic [$clog2(DEPTH)-1:0] raddr0,
    input  logic [$clog2(DEPTH)-1:0] raddr1,
    output fq_entry_t                rdata0,
    output fq_entry_t                rdata1
);

    fq_entry_t mem [DEPTH];

    // Write both halves of an accepted bundle; the two addresses never collide.
    // NOTE: no reset on the array -- validity lives in the pointers/count, so
    // stale data is never observed and the storage stays plain flops/RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            mem[waddr0] <= wdata0;
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between the 2-wide fetch stage and decode.
// Accepts one two-instruction bundle per cycle, presents the two oldest
// instructions in program order, absorbs back-pressure and empties on flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input logic          clk,
    input logic          reset_n,
    fetch_queue_if.slave fq
);

    localparam int             PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_TWO   = (PTR_W+1)'(2);
    localparam logic [PTR_W:0] CNT_DEPTH = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             ready;
    logic             valid0;
    logic             valid1;
    logic             enq;
    logic [PTR_W:0]   pops;
    fq_entry_t        wdata0;
    fq_entry_t        wdata1;
    fq_entry_t        rdata0;
    fq_entry_t        rdata1;

    // Ready and slot validity come only from the registered count.
    assign ready  = count <= (CNT_DEPTH - CNT_TWO);
    assign valid0 = count >= CNT_ONE;
    assign valid1 = count >= CNT_TWO;

    // Decide this cycle's enqueue and pop count; take[1] only counts alongside take[0].
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        enq  = 1'b0;
        pops = '0;
        if (!fq.flush) begin
            enq = fq.in_valid && ready;
            if (fq.out_take[0] && valid0) begin
                pops = CNT_ONE;
                if (fq.out_take[1] && valid1) begin
                    pops = CNT_TWO;
                end
            end
        end
    end

    assign wdata0 = '{pc: fq.in_pc, inst: fq.in_inst1};
    assign wdata1 = '{pc: fq.in_pc + PC_W'(PC_STEP), inst: fq.in_inst2};

    // Pointer and occupancy registers; flush outranks enqueue and dequeue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (fq.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pops);
            tail  <= enq ? tail + PTR_W'(2) : tail;
            count <= count + (enq ? CNT_TWO : '0) - pops;
        end
    end

    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk    (clk),
        .we     (enq),
        .waddr0 (tail),
        .waddr1 (tail + PTR_W'(1)),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .raddr0 (head),
        .raddr1 (head + PTR_W'(1)),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    assign fq.in_ready  = ready;
    assign fq.out_valid = {valid1, valid0};
    assign fq.out_inst0 = valid0 ? rdata0.inst : '0;
    assign fq.out_pc0   = valid0 ? rdata0.pc   : '0;
    assign fq.out_inst1 = valid1 ? rdata1.inst : '0;
    assign fq.out_pc1   = valid1 ? rdata1.pc   : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue: each row drives one cycle of
// inputs and lists the hand-computed outputs after that clock edge.
module tb_fetch_queue;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    fetch_queue_if bus ();

    fetch_queue #(.DEPTH(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fq      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        in_valid;
        logic [7:0]  pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [1:0]  take;
        logic        flush;
        logic [1:0]  e_valid;
        logic        e_ready;
        logic [3:0]  e_count;
        logic [7:0]  e_pc0;
        logic [7:0]  e_pc1;
        logic [31:0] e_inst0;
        logic [31:0] e_inst1;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic iv, input logic [7:0] pc,
                       input logic [31:0] i1, input logic [31:0] i2,
                       input logic [1:0] take, input logic flush,
                       input logic [1:0] ev, input logic er, input logic [3:0] ec,
                       input logic [7:0] ep0, input logic [7:0] ep1,
                       input logic [31:0] ei0, input logic [31:0] ei1);
        vec_t v;
        v.name = name; v.in_valid = iv; v.pc = pc; v.i1 = i1; v.i2 = i2;
        v.take = take; v.flush = flush; v.e_valid = ev; v.e_ready = er;
        v.e_count = ec; v.e_pc0 = ep0; v.e_pc1 = ep1; v.e_inst0 = ei0; v.e_inst1 = ei1;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] ev, input logic er,
                                 input logic [3:0] ec, input logic [7:0] ep0, input logic [7:0] ep1,
                                 input logic [31:0] ei0, input logic [31:0] ei1);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, ".in_ready"},  32'(bus.in_ready),  32'(er));
        check({tag, ".count"},     32'(dut.count),     32'(ec));
        check({tag, ".out_pc0"},   32'(bus.out_pc0),   32'(ep0));
        check({tag, ".out_pc1"},   32'(bus.out_pc1),   32'(ep1));
        check({tag, ".out_inst0"}, bus.out_inst0,      ei0);
        check({tag, ".out_inst1"}, bus.out_inst1,      ei1);
    endtask

    task automatic drive_idle();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_pc    = '0;
        bus.in_inst1 = '0;
        bus.in_inst2 = '0;
        bus.out_take = 2'b00;
    endtask

    initial begin
        // name, in_valid, pc, inst1, inst2, take, flush | valid, ready, count, pc0, pc1, inst0, inst1
        add("push_first",   1, 8'h10, 32'hAAAA0001, 32'hAAAA0002, 2'b00, 0, 2'b11, 1, 2, 8'h10, 8'h14, 32'hAAAA0001, 32'hAAAA0002);
        add("push_2",       1, 8'h18, 32'hAAAA0003, 32'hAAAA0004, 2'b00, 0, 2'b11, 1, 4, 8'h10, 8'h14, 32'hAAAA0001, 32'hAAAA0002);
        add("push_3",       1, 8'h20, 32'hAAAA0005, 32'hAAAA0006, 2'b00, 0, 2'b11, 1, 6, 8'h10, 8'h14, 32'hAAAA0001, 32'hAAAA0002);
        add("push_4_full",  1, 8'h28, 32'hAAAA0007, 32'hAAAA0008, 2'b00, 0, 2'b11, 0, 8, 8'h10, 8'h14, 32'hAAAA0001, 32'hAAAA0002);
        add("push_5_drop",  1, 8'h30, 32'hAAAA0009, 32'hAAAA000A, 2'b00, 0, 2'b11, 0, 8, 8'h10, 8'h14, 32'hAAAA0001, 32'hAAAA0002);
        add("full_take11",  1, 8'h40, 32'hAAAA000B, 32'hAAAA000C, 2'b11, 0, 2'b11, 1, 6, 8'h18, 8'h1C, 32'hAAAA0003, 32'hAAAA0004);
        add("take01",       0, 8'h00, 32'h0,        32'h0,        2'b01, 0, 2'b11, 1, 5, 8'h1C, 8'h20, 32'hAAAA0004, 32'hAAAA0005);
        add("take10_ign",   0, 8'h00, 32'h0,        32'h0,        2'b10, 0, 2'b11, 1, 5, 8'h1C, 8'h20, 32'hAAAA0004, 32'hAAAA0005);
        add("push_pc_fc",   1, 8'hFC, 32'hCCCC0001, 32'hCCCC0002, 2'b00, 0, 2'b11, 0, 7, 8'h1C, 8'h20, 32'hAAAA0004, 32'hAAAA0005);
        add("drain_a",      0, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2'b11, 1, 5, 8'h24, 8'h28, 32'hAAAA0006, 32'hAAAA0007);
        add("drain_b",      0, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2'b11, 1, 3, 8'h2C, 8'hFC, 32'hAAAA0008, 32'hCCCC0001);
        add("pc_wrap",      0, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2'b01, 1, 1, 8'h00, 8'h00, 32'hCCCC0002, 32'h0);
        add("enq_deq_01",   1, 8'h50, 32'hDDDD0001, 32'hDDDD0002, 2'b01, 0, 2'b11, 1, 2, 8'h50, 8'h54, 32'hDDDD0001, 32'hDDDD0002);
        add("enq_deq_11",   1, 8'h60, 32'hEEEE0001, 32'hEEEE0002, 2'b11, 0, 2'b11, 1, 2, 8'h60, 8'h64, 32'hEEEE0001, 32'hEEEE0002);
        add("drain_empty",  0, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2'b00, 1, 0, 8'h00, 8'h00, 32'h0,        32'h0);
        add("take_empty",   0, 8'h00, 32'h0,        32'h0,        2'b11, 0, 2'b00, 1, 0, 8'h00, 8'h00, 32'h0,        32'h0);
        add("fill_a",       1, 8'h70, 32'hF0F00001, 32'hF0F00002, 2'b00, 0, 2'b11, 1, 2, 8'h70, 8'h74, 32'hF0F00001, 32'hF0F00002);
        add("fill_b",       1, 8'h78, 32'hF0F00003, 32'hF0F00004, 2'b00, 0, 2'b11, 1, 4, 8'h70, 8'h74, 32'hF0F00001, 32'hF0F00002);
        add("fill_c",       1, 8'h80, 32'hF0F00005, 32'hF0F00006, 2'b00, 0, 2'b11, 1, 6, 8'h70, 8'h74, 32'hF0F00001, 32'hF0F00002);
        add("to_five",      0, 8'h00, 32'h0,        32'h0,        2'b01, 0, 2'b11, 1, 5, 8'h74, 8'h78, 32'hF0F00002, 32'hF0F00003);
        add("flush_all",    1, 8'h90, 32'h99990001, 32'h99990002, 2'b11, 1, 2'b00, 1, 0, 8'h00, 8'h00, 32'h0,        32'h0);
        add("post_flush",   1, 8'h90, 32'h99990001, 32'h99990002, 2'b00, 0, 2'b11, 1, 2, 8'h90, 8'h94, 32'h99990001, 32'h99990002);
        add("post_flush_b", 1, 8'h98, 32'h99990003, 32'h99990004, 2'b00, 0, 2'b11, 1, 4, 8'h90, 8'h94, 32'h99990001, 32'h99990002);
        add("three_left",   0, 8'h00, 32'h0,        32'h0,        2'b01, 0, 2'b11, 1, 3, 8'h94, 8'h98, 32'h99990002, 32'h99990003);

        // Reset state.
        drive_idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Table: drive on the falling edge, check just after the rising edge.
        foreach (vecs[i]) begin
            @(negedge clk);
            bus.in_valid = vecs[i].in_valid;
            bus.in_pc    = vecs[i].pc;
            bus.in_inst1 = vecs[i].i1;
            bus.in_inst2 = vecs[i].i2;
            bus.out_take = vecs[i].take;
            bus.flush    = vecs[i].flush;
            @(posedge clk);
            #1;
            check_outputs(vecs[i].name, vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_count,
                          vecs[i].e_pc0, vecs[i].e_pc1, vecs[i].e_inst0, vecs[i].e_inst1);
        end

        // Asynchronous reset mid-cycle with three entries present.
        @(negedge clk);
        drive_idle();
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_reset", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("after_reset", 2'b00, 1'b1, 4'd0, 8'h00, 8'h00, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
